dekatron_step_sequencer: RTL and testbench

//  Upstream driver for one one-hot decade counter stage (10-bit ring, Step/Reverse inputs).

---
 rtl/dekatron_step_sequencer_if.sv | 28 ++
 rtl/dekatron_step_sequencer.sv | 125 ++++++++++++
 tb/tb_dekatron_step_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dekatron_step_sequencer_if.sv
// Command handshake plus stage-side signals between an upstream controller and the step sequencer.
// The master side issues commands; the slave side is the sequencer driving the decade stage.
interface dekatron_step_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             CmdValid;
  logic             CmdReady;
  logic [CNT_W-1:0] CmdCount;
  logic             CmdReverse;
  logic [9:0]       DekIn;
  logic             Step;
  logic             Reverse;
  logic             Busy;
  logic             Done;
  logic             Carry;
  logic             Borrow;
  logic             Fault;

  modport master (
    output CmdValid, CmdCount, CmdReverse, DekIn,
    input  CmdReady, Step, Reverse, Busy, Done, Carry, Borrow, Fault
  );

  modport slave (
    input  CmdValid, CmdCount, CmdReverse, DekIn,
    output CmdReady, Step, Reverse, Busy, Done, Carry, Borrow, Fault
  );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Turns "move N, direction D" commands into N timed Step pulses for a one-hot decade stage.
// First Step edge 2 cycles after accept, one pulse per STEP_HIGH+STEP_LOW; CmdReady low while busy.
module dekatron_step_sequencer #(
  parameter int STEP_HIGH = 2,
  parameter int STEP_LOW  = 2,
  parameter int CNT_W     = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  dekatron_step_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  localparam int PH_MAX = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [PH_W-1:0]  ph;
  logic             step;
  logic             reverse;
  logic             busy;
  logic             done;
  logic             carry;
  logic             borrow;
  logic             fault;
  logic             cmd_ready;

  logic one_hot;
  logic high_end;
  logic low_end;
  logic launch;

  assign one_hot  = (bus.DekIn != 10'd0) && ((bus.DekIn & (bus.DekIn - 10'd1)) == 10'd0);
  assign high_end = (ph == PH_W'(STEP_HIGH - 1));
  assign low_end  = (ph == PH_W'(STEP_LOW - 1));
  // Every rising Step edge is preceded by a sanity check of the stage's current position.
  assign launch   = (state == SETUP) || ((state == LOW) && low_end && (rem != '0));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      ph        <= '0;
      step      <= 1'b0;
      reverse   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      fault     <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done   <= 1'b0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      if (launch) begin
        ph <= '0;
        if (!one_hot) begin
          fault <= 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          step   <= 1'b1;
          carry  <= !reverse && bus.DekIn[9];
          borrow <= reverse && bus.DekIn[0];
          state  <= HIGH;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.CmdValid) begin
              rem       <= bus.CmdCount;
              reverse   <= bus.CmdReverse;
              fault     <= 1'b0;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              ph        <= '0;
              if (bus.CmdCount == '0) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= SETUP;
              end
            end
          end
          HIGH: begin
            if (high_end) begin
              step  <= 1'b0;
              rem   <= rem - CNT_W'(1);
              ph    <= '0;
              state <= LOW;
            end else begin
              ph <= ph + PH_W'(1);
            end
          end
          LOW: begin
            // Reaching the end of LOW without a launch means rem is exhausted.
            if (low_end) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ph <= ph + PH_W'(1);
            end
          end
          DONE: begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.CmdReady = cmd_ready;
  assign bus.Step     = step;
  assign bus.Reverse  = reverse;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Carry    = carry;
  assign bus.Borrow   = borrow;
  assign bus.Fault    = fault;
endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for the step sequencer: a one-hot ring stands in for the decade stage, and each command's
// per-cycle traces are compared against expectations computed from positions and pulse arithmetic.
module tb_dekatron_step_sequencer;
  logic       Clk;
  logic       Rst_n;
  logic [9:0] dek;
  int         total_cnt;
  int         pass_cnt;

  dekatron_step_sequencer_if #(.CNT_W(4)) bus ();

  dekatron_step_sequencer #(
    .STEP_HIGH(2),
    .STEP_LOW (2),
    .CNT_W    (4)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  assign bus.DekIn = dek;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stage model: the ring advances on every rising Step edge in the direction of Reverse.
  always @(posedge bus.Step) begin
    if (bus.Reverse) dek = {dek[0], dek[9:1]};
    else             dek = {dek[8:0], dek[9]};
  end

  // Issue one command and compare whole-command traces. Cycle 0 is the accept cycle.
  task automatic run_cmd(input int n, input bit rv, input bit keep, input bit wait_first);
    logic [63:0] e_step, e_carry, e_borrow, e_done, e_busy, e_fault, e_rev;
    logic [63:0] a_step, a_carry, a_borrow, a_done, a_busy, a_ready, a_fault, a_rev;
    logic [63:0] len_mask, late_mask;
    logic [9:0]  start, e_end;
    int          done_c, p, d, q;
    bit          bad;

    start = dek;
    bad   = ($countones(start) != 1);
    p     = 0;
    for (int i = 0; i < 10; i++) if (start[i]) p = i;
    d = rv ? -1 : 1;
    if (n == 0)   done_c = 1;
    else if (bad) done_c = 2;
    else          done_c = 2 + 4 * n;

    e_step = '0; e_carry = '0; e_borrow = '0; e_done = '0; e_busy = '0; e_fault = '0; e_rev = '0;
    if (!bad) begin
      for (int k = 0; k < n; k++) begin
        q = ((p + d * k) % 10 + 10) % 10;
        e_step[2 + 4 * k] = 1'b1;
        e_step[3 + 4 * k] = 1'b1;
        if (!rv && q == 9) e_carry[2 + 4 * k] = 1'b1;
        if (rv && q == 0)  e_borrow[2 + 4 * k] = 1'b1;
      end
    end
    e_done[done_c] = 1'b1;
    len_mask = '0; late_mask = '0;
    for (int c = 0; c <= done_c + 1; c++) begin
      len_mask[c] = 1'b1;
      if (c >= 1) begin
        late_mask[c] = 1'b1;
        e_rev[c]     = rv;
        if (bad && n > 0 && c >= 2) e_fault[c] = 1'b1;
      end
      if (c >= 1 && c <= done_c) e_busy[c] = 1'b1;
    end
    if (bad) e_end = start;
    else     e_end = 10'd1 << (((p + d * n) % 10 + 10) % 10);

    if (wait_first) @(negedge Clk);
    bus.CmdValid   = 1'b1;
    bus.CmdCount   = 4'(n);
    bus.CmdReverse = rv;
    a_step = '0; a_carry = '0; a_borrow = '0; a_done = '0; a_busy = '0; a_ready = '0; a_fault = '0; a_rev = '0;
    for (int c = 0; c <= done_c + 1; c++) begin
      if (c > 0) @(negedge Clk);
      if (c == 1) begin
        // A held CmdValid with a changing count must be ignored until the sequencer is idle.
        if (keep) bus.CmdCount = 4'($urandom);
        else      bus.CmdValid = 1'b0;
      end
      a_step[c]   = bus.Step;
      a_carry[c]  = bus.Carry;
      a_borrow[c] = bus.Borrow;
      a_done[c]   = bus.Done;
      a_busy[c]   = bus.Busy;
      a_ready[c]  = bus.CmdReady;
      a_fault[c]  = bus.Fault;
      a_rev[c]    = bus.Reverse;
    end

    total_cnt++;
    if (a_step !== e_step) $display("FAIL step_trace n=%0d rev=%0d got=%h exp=%h", n, rv, a_step, e_step);
    else pass_cnt++;
    total_cnt++;
    if (a_carry !== e_carry) $display("FAIL carry_trace n=%0d rev=%0d got=%h exp=%h", n, rv, a_carry, e_carry);
    else pass_cnt++;
    total_cnt++;
    if (a_borrow !== e_borrow) $display("FAIL borrow_trace n=%0d rev=%0d got=%h exp=%h", n, rv, a_borrow, e_borrow);
    else pass_cnt++;
    total_cnt++;
    if (a_done !== e_done) $display("FAIL done_trace n=%0d rev=%0d got=%h exp=%h", n, rv, a_done, e_done);
    else pass_cnt++;
    total_cnt++;
    if (a_busy !== e_busy) $display("FAIL busy_trace n=%0d rev=%0d got=%h exp=%h", n, rv, a_busy, e_busy);
    else pass_cnt++;
    total_cnt++;
    if (a_ready !== (~e_busy & len_mask)) $display("FAIL ready_trace n=%0d got=%h exp=%h", n, a_ready, ~e_busy & len_mask);
    else pass_cnt++;
    total_cnt++;
    if ((a_fault & late_mask) !== e_fault) $display("FAIL fault_trace n=%0d got=%h exp=%h", n, a_fault & late_mask, e_fault);
    else pass_cnt++;
    total_cnt++;
    if ((a_rev & late_mask) !== e_rev) $display("FAIL reverse_trace n=%0d got=%h exp=%h", n, a_rev & late_mask, e_rev);
    else pass_cnt++;
    total_cnt++;
    if (dek !== e_end) $display("FAIL end_position n=%0d rev=%0d got=%h exp=%h", n, rv, dek, e_end);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Rst_n          = 1'b1;
    bus.CmdValid   = 1'b0;
    bus.CmdCount   = '0;
    bus.CmdReverse = 1'b0;
    dek            = 10'h001;
    #2 Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    total_cnt++;
    if ({bus.CmdReady, bus.Step, bus.Reverse, bus.Busy, bus.Done, bus.Carry, bus.Borrow, bus.Fault} !== 8'b1000_0000)
      $display("FAIL reset_outputs got=%b exp=10000000",
               {bus.CmdReady, bus.Step, bus.Reverse, bus.Busy, bus.Done, bus.Carry, bus.Borrow, bus.Fault});
    else pass_cnt++;
    Rst_n = 1'b1;
    @(negedge Clk);
    total_cnt++;
    if ({bus.CmdReady, bus.Busy, bus.Step} !== 3'b100)
      $display("FAIL idle_after_reset got=%b exp=100", {bus.CmdReady, bus.Busy, bus.Step});
    else pass_cnt++;
  endtask

  task automatic test_forward();
    dek = 10'h001;
    run_cmd(3, 1'b0, 1'b0, 1'b1);
    dek = 10'h100;
    run_cmd(3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reverse();
    dek = 10'h001;
    run_cmd(2, 1'b1, 1'b0, 1'b1);
    dek = 10'h200;
    run_cmd(1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_zero();
    dek = 10'h020;
    run_cmd(0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_fault();
    dek = 10'h003;
    run_cmd(5, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (bus.Fault !== 1'b1) $display("FAIL fault_sticky got=%b exp=1", bus.Fault);
    else pass_cnt++;
    dek = 10'h000;
    run_cmd(2, 1'b1, 1'b0, 1'b1);
    dek = 10'h010;
    run_cmd(2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [9:0] v;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 4) == 0) v = 10'($urandom);
      else                           v = 10'd1 << $urandom_range(0, 9);
      dek = v;
      run_cmd(int'($urandom_range(0, 15)), 1'($urandom), 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    dek = 10'h008;
    run_cmd(4, 1'b0, 1'b1, 1'b1);
    run_cmd(2, 1'b1, 1'b1, 1'b0);
    run_cmd(3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    dek = 10'h001;
    @(negedge Clk);
    bus.CmdValid   = 1'b1;
    bus.CmdCount   = 4'd5;
    bus.CmdReverse = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      if (c == 1) bus.CmdValid = 1'b0;
    end
    total_cnt++;
    if (bus.Step !== 1'b1) $display("FAIL step_before_reset got=%b exp=1", bus.Step);
    else pass_cnt++;
    Rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.Step !== 1'b0) $display("FAIL step_async_drop got=%b exp=0", bus.Step);
    else pass_cnt++;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    total_cnt++;
    if ({bus.CmdReady, bus.Step, bus.Busy, bus.Done, bus.Carry, bus.Borrow, bus.Fault} !== 7'b100_0000)
      $display("FAIL after_mid_reset got=%b exp=1000000",
               {bus.CmdReady, bus.Step, bus.Busy, bus.Done, bus.Carry, bus.Borrow, bus.Fault});
    else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_zero();
    test_fault();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
